// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit:
//               controller state encoding, funct3 size/sign codes and the
//               default data-memory limit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Controller states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_DATA  = 3'd2,
        S_WR       = 3'd3,
        S_RESP     = 3'd4
    } lsu_state_t;

    // funct3 access size / sign codes
    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    // First byte address outside data memory
    localparam logic [31:0] c_addr_limit_default = 32'd1604;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic. Extracts and sign/zero-extends the
//               addressed byte/halfword of a read word, and merges store data
//               into the addressed lane of a read word for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane extract with extension, and lane replace for SB/SH read-modify-write
    always_comb begin
        w_byte       = i_rd_word[{i_byte_off, 3'b000} +: 8];
        w_half       = i_byte_off[1] ? i_rd_word[31:16] : i_rd_word[15:0];
        o_load_data  = i_rd_word;
        o_merge_word = i_rd_word;
        case (i_funct3)
            c_f3_b:  o_load_data = {{24{w_byte[7]}}, w_byte};
            c_f3_bu: o_load_data = {24'h000000, w_byte};
            c_f3_h:  o_load_data = {{16{w_half[15]}}, w_half};
            c_f3_hu: o_load_data = {16'h0000, w_half};
            default: o_load_data = i_rd_word;
        endcase
        case (i_funct3[1:0])
            2'b00:   o_merge_word[{i_byte_off, 3'b000} +: 8]         = i_wdata[7:0];
            2'b01:   o_merge_word[{i_byte_off[1], 4'b0000} +: 16]    = i_wdata[15:0];
            default: o_merge_word = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit in front of a word-wide
//               data memory with one-cycle read latency. Sub-word stores are
//               done as read-modify-write; faulting accesses never touch
//               memory and answer in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = c_addr_limit_default
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_word;

    assign req_ready  = (r_state == S_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_fault = r_fault;
    assign mem_a      = {r_addr[31:2], 2'b00};
    // Reset gates the strobe directly so a reset cycle can never write
    assign mem_we     = rstn && ((r_state == S_WR) || ((r_state == S_RD_DATA) && r_store));

    // Classify the offered request: range, alignment and illegal encodings
    always_comb begin
        w_fault = (req_addr >= ADDR_LIMIT);
        case (req_funct3)
            c_f3_b:  ;
            c_f3_bu: if (req_store) w_fault = 1'b1;
            c_f3_h:  if (req_addr[0]) w_fault = 1'b1;
            c_f3_hu: if (req_store || req_addr[0]) w_fault = 1'b1;
            c_f3_w:  if (req_addr[1:0] != 2'b00) w_fault = 1'b1;
            default: w_fault = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_fault)
                        w_state_nxt = S_RESP;
                    else if (req_store && (req_funct3 == c_f3_w))
                        w_state_nxt = S_WR;
                    else
                        w_state_nxt = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: w_state_nxt = S_RD_DATA;
            S_RD_DATA:  w_state_nxt = S_RESP;
            S_WR:       w_state_nxt = S_RESP;
            S_RESP:     if (resp_ready) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Write word: merged lane for sub-word stores, raw data for SW
    always_comb begin
        mem_wd = 32'h0;
        if ((r_state == S_RD_DATA) && r_store)
            mem_wd = w_merge_word;
        else if (r_state == S_WR)
            mem_wd = r_wdata;
    end

    // State register, request latch and response data register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_store  <= req_store;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_fault  <= w_fault;
                r_rdata  <= 32'h0;
            end
            if ((r_state == S_RD_DATA) && !r_store)
                r_rdata <= w_load_data;
        end
    end

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_byte_off   (r_addr[1:0]),
        .i_rd_word    (mem_rd),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_word (w_merge_word)
    );

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit. A byte-addressed
//               reference memory predicts every response; a monitor checks
//               responses, latency, write-pulse counts and stall stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam logic [31:0] LIMIT = 32'd1604;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    load_store_unit #(.ADDR_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: word wide, registered read, bench back-door write port
    logic [31:0] env_mem [0:511];
    logic        tb_we = 1'b0;
    logic [31:0] tb_wa = 32'h0;
    logic [31:0] tb_wd = 32'h0;
    always @(posedge clk) begin
        if (tb_we)
            env_mem[tb_wa[10:2]] <= tb_wd;
        else if (mem_we)
            env_mem[mem_a[10:2]] <= mem_wd;
        mem_rd <= env_mem[mem_a[10:2]];
    end

    // Reference model state: plain byte array
    logic [7:0] ref_mem [0:2047];

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
        int          we_base;
        int          nwe;
    } exp_t;
    exp_t sbq[$];

    int  total = 0;
    int  bad = 0;
    int  we_cnt = 0;
    bit  seen = 0;
    bit  hold = 0;
    bit  rr_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural behaviour of one access against the byte memory
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                         output int lat, output int nwe);
        int          size;
        logic [31:0] raw;
        size = 1 << f3[1:0];
        flt  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]) ||
               (a >= LIMIT) || ((a % size) != 0);
        rd   = 32'h0;
        lat  = 1;
        nwe  = 0;
        raw  = 32'h0;
        if (flt) return;
        if (st) begin
            for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
            lat = (size == 4) ? 2 : 3;
            nwe = 1;
        end else begin
            for (int i = 0; i < size; i++) raw[8*i +: 8] = ref_mem[a + i];
            if (size == 1)
                rd = f3[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            else if (size == 2)
                rd = f3[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            else
                rd = raw;
            lat = 3;
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = v;
        @(posedge clk); #1;
        tb_we = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[{a[31:2], 2'b00} + i] = v[8*i +: 8];
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        exp_t e;
        int   n;
        n = 0;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            check("req_ready_timeout", {31'h0, req_ready}, 32'h1);
            return;
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model(st, f3, a, wd, e.rdata, e.fault, e.lat, e.nwe);
        e.acc     = cyc;
        e.we_base = we_cnt;
        sbq.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
        if (sbq.size() != 0) check("drain_timeout", 32'(sbq.size()), 32'h0);
    endtask

    // Monitor: compare every response cycle against the scoreboard head
    always @(negedge clk) begin
        if (!rstn) begin
            seen = 0;
        end else begin
            if (mem_we) we_cnt++;
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_resp", {31'h0, resp_valid}, 32'h0);
                end else begin
                    if (!seen) begin
                        check("latency", 32'(cyc - sbq[0].acc + 1), 32'(sbq[0].lat));
                        seen = 1;
                    end
                    check("resp_rdata", resp_rdata, sbq[0].rdata);
                    check("resp_fault", {31'h0, resp_fault}, {31'h0, sbq[0].fault});
                    check("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
                    if (resp_ready) begin
                        check("we_pulses", 32'(we_cnt - sbq[0].we_base), 32'(sbq[0].nwe));
                        void'(sbq.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    // Consumer side: always ready, or randomly ready, unless held by a directed test
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!hold) resp_ready = rr_mode ? ($urandom % 4 != 0) : 1'b1;
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] old;
        logic [2:0]  f3;
        int          nbad;

        // Fill memory while held in reset
        for (int w = 0; w < 512; w++) set_word(32'(w * 4), $urandom);
        rstn = 1'b1;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);

        // Word load
        set_word(32'h100, 32'h8899AABB);
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        wait_drain();

        // Signed / unsigned byte
        set_word(32'h100, 32'h80FF7F01);
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        issue(1'b0, 3'b100, 32'h103, 32'h0);
        wait_drain();

        // Halfword store by read-modify-write, then read back
        set_word(32'h100, 32'h11223344);
        issue(1'b1, 3'b001, 32'h102, 32'h0000BEEF);
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        wait_drain();
        check("sh_mem_word", env_mem[32'h100 >> 2], 32'hBEEF3344);

        // Misaligned load and out-of-range store
        issue(1'b0, 3'b010, 32'h101, 32'h0);
        issue(1'b1, 3'b010, 32'h644, 32'h12345678);
        wait_drain();

        // Stalled response stays stable
        hold = 1;
        resp_ready = 1'b0;
        issue(1'b0, 3'b101, 32'h102, 32'h0);
        for (int n = 0; n < 20 && !resp_valid; n++) begin @(posedge clk); #1; end
        repeat (5) begin @(posedge clk); #1; end
        resp_ready = 1'b1;
        hold = 0;
        wait_drain();

        // Reset in the RD_DATA cycle of a byte store
        old = env_mem[32'h108 >> 2];
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h109; req_wdata = 32'h000000AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("sb_rd_data_we", {31'h0, mem_we}, 32'h1);
        rstn = 1'b0;
        #1;
        check("reset_gates_we", {31'h0, mem_we}, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        check("post_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_rdata", resp_rdata, 32'h0);
        check("post_rst_mem_unchanged", env_mem[32'h108 >> 2], old);

        // Randomized traffic with random back-pressure
        rr_mode = 1;
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:            a = $urandom;
                1, 2, 3, 4:   a = 32'h600 + 32'($urandom_range(0, 127));
                default:      a = 32'h100 + 32'($urandom_range(0, 31));
            endcase
            f3 = 3'($urandom_range(0, 7));
            issue(1'($urandom_range(0, 1)), f3, a, $urandom);
        end
        rr_mode = 0;
        wait_drain();

        // Final memory image against the reference
        nbad = 0;
        for (int w = 0; w < 401; w++) begin
            if (env_mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]})
                nbad++;
        end
        check("final_mem_words_wrong", 32'(nbad), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use one clock, clk; reset is rstn, synchronous and active-low.
REQ-002 Parameter ADDR_LIMIT, default 32'd1604, SHALL be the first byte address outside data memory.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rstn  in  1  synchronous active-low reset.
REQ-005 req_valid  in  1  execute stage offers an access.
REQ-006 req_ready  out  1  unit accepts an access; high only in IDLE.
REQ-007 req_store  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_ready  in  1  consumer takes the response.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores and faults.
REQ-014 resp_fault  out  1  misaligned, out-of-range or illegal access.
REQ-015 mem_we  out  1  write strobe to the word-wide data memory.
REQ-016 mem_a  out  32  word-aligned byte address; bits [1:0] always 00.
REQ-017 mem_wd  out  32  write word.
REQ-018 mem_rd  in  32  read word, valid one cycle after mem_a is presented.

Function
REQ-019 A request SHALL be accepted on a rising edge with req_valid && req_ready; all request fields are latched then.
REQ-020 States SHALL be IDLE, RD_ISSUE, RD_DATA, WR, RESP.
REQ-021 At accept: fault -> RESP; SW -> WR; any load, SB or SH -> RD_ISSUE.
REQ-022 Fault conditions: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; addr >= ADDR_LIMIT; funct3 011/110/111; store with funct3 100/101.
REQ-023 A faulting access SHALL cause no mem_we pulse.
REQ-024 RD_ISSUE SHALL drive mem_a = {addr[31:2],2'b00} with mem_we=0, then go to RD_DATA.
REQ-025 RD_DATA, load: byte/halfword selected by addr[1:0]/addr[1], sign- or zero-extended, registered into resp_rdata; next state RESP.
REQ-026 RD_DATA, SB/SH: mem_we=1 same cycle; mem_wd = mem_rd with the addressed lane replaced by wdata[7:0]/[15:0]; next state RESP.
REQ-027 WR (SW only): mem_we=1, mem_wd=wdata for exactly one cycle; next state RESP.
REQ-028 mem_we SHALL be high for at most one cycle per access and never in IDLE, RD_ISSUE or RESP.
REQ-029 RESP SHALL hold resp_valid=1 with stable resp_rdata and resp_fault until resp_ready=1, then return to IDLE.
REQ-030 Latency from accept edge to first resp_valid cycle: fault 1, SW 2, loads/SB/SH 3 cycles; resp_ready held high gives back-to-back throughput.
REQ-031 req_ready SHALL be 0 in RESP; no new accept in the cycle resp_ready completes a response.

Reset
REQ-032 rstn=0 at a rising edge SHALL force IDLE and clear resp_valid, resp_fault, resp_rdata and latched request fields, including mid-access.
REQ-033 mem_we SHALL be gated to 0 combinationally while rstn=0, so no write occurs during a reset cycle.
REQ-034 After reset, mem_a and mem_wd SHALL be 0 and req_ready=1 from the first cycle with rstn=1.

Structure
REQ-035 Package lsu_pkg SHALL hold the state enum, funct3 localparams and the default ADDR_LIMIT.
REQ-036 Sub-module lsu_align SHALL be a combinational lane extract/sign-extend and lane merge, instantiated once.

Verification
REQ-037 LW at 0x100, memory word 0x8899AABB -> resp_valid 3 cycles after accept, rdata=0x8899AABB, fault=0.
REQ-038 LB at 0x103 and LBU at 0x103, word 0x80FF7F01 -> rdata 0xFFFFFF80 and 0x00000080.
REQ-039 SH wdata 0x0000BEEF at 0x102, old word 0x11223344 -> single mem_we, mem_wd=0xBEEF3344; subsequent LW returns 0xBEEF3344.
REQ-040 LW at 0x101, then SW at 0x644 -> both give fault=1 one cycle after accept, rdata=0, no mem_we pulse.
REQ-041 resp_ready held 0 for 5 cycles -> resp_valid and data stable; req_ready=0 throughout.
REQ-042 rstn=0 during SB's RD_DATA cycle -> mem_we=0, memory unchanged, IDLE with resp_valid=0 on the next cycle.
